// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NUM_REQ
// writeback requesters, with a one-deep output stage, pending bitmap and contention counter.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        regWrite,
  output logic [ADDR_W-1:0]           writeRegister,
  output logic [DATA_W-1:0]           writeData,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [2**ADDR_W-1:0]        pending,
  output logic [CNT_W-1:0]            contention
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptrNext;
  logic [IDX_W-1:0]  grantIdx;
  logic [IDX_W-1:0]  grantIdReg;
  logic              grantFound;
  logic              doGrant;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              stageValid;
  logic [ADDR_W-1:0] stageAddr;
  logic [DATA_W-1:0] stageData;
  logic [CNT_W-1:0]  contentionCnt;
  logic              contended;

  function automatic logic [IDX_W-1:0] wrapIdx(input int value);
    return IDX_W'(value % NUM_REQ);
  endfunction

  // Scan from the round-robin pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grantFound && req_valid[wrapIdx(int'(ptr) + k)]) begin
        grantFound = 1'b1;
        grantIdx   = wrapIdx(int'(ptr) + k);
      end
    end
  end

  assign doGrant   = grantFound && !hold && !reset;
  assign ptrNext   = wrapIdx(int'(grantIdx) + 1);
  assign selAddr   = req_addr[int'(grantIdx)*ADDR_W +: ADDR_W];
  assign selData   = req_data[int'(grantIdx)*DATA_W +: DATA_W];
  assign contended = ($countones(req_valid) >= 2);

  always_comb begin
    req_ready = '0;
    if (doGrant) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  // Writes to register 0 are consumed but never enter the stage, so the address/data
  // registers keep showing the last real write.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr           <= '0;
      grantIdReg    <= '0;
      stageValid    <= 1'b0;
      stageAddr     <= '0;
      stageData     <= '0;
      contentionCnt <= '0;
    end else begin
      if (doGrant) begin
        ptr        <= ptrNext;
        grantIdReg <= grantIdx;
        stageValid <= (selAddr != '0);
        if (selAddr != '0) begin
          stageAddr <= selAddr;
          stageData <= selData;
        end
      end else begin
        stageValid <= 1'b0;
      end
      if (contended && (contentionCnt != {CNT_W{1'b1}})) begin
        contentionCnt <= contentionCnt + CNT_W'(1);
      end
    end
  end

  // Gating with reset drops a write that is sitting in the stage when reset arrives.
  assign regWrite      = stageValid && !reset;
  assign writeRegister = stageAddr;
  assign writeData     = stageData;
  assign grant_id      = grantIdReg;
  assign contention    = contentionCnt;

  always_comb begin
    pending = '0;
    if (regWrite) begin
      pending[stageAddr] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter plus hand-written reset and saturation sequences.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic [2:0]  reqValid;
  logic [8:0]  reqAddr;
  logic [23:0] reqData;

  logic [2:0]  reqReady;
  logic        regWrite;
  logic [2:0]  writeRegister;
  logic [7:0]  writeData;
  logic [1:0]  grantId;
  logic [7:0]  pending;
  logic [7:0]  contention;

  logic [2:0]  reqReadyS;
  logic        regWriteS;
  logic [2:0]  writeRegisterS;
  logic [7:0]  writeDataS;
  logic [1:0]  grantIdS;
  logic [7:0]  pendingS;
  logic [1:0]  contentionS;

  logic [7:0]  rf [8];

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        hold;
    logic [2:0]  valid;
    logic [8:0]  addr;
    logic [23:0] data;
    logic [2:0]  expReady;
    logic        expRegWrite;
    logic [2:0]  expWriteReg;
    logic [7:0]  expWriteData;
    logic [1:0]  expGrantId;
    logic [7:0]  expPending;
    logic [7:0]  expContention;
  } vec_t;

  localparam logic [8:0]  ADDRS  = {3'd6, 3'd5, 3'd3};
  localparam logic [8:0]  ADDRS0 = {3'd0, 3'd5, 3'd3};
  localparam logic [23:0] DATAS  = {8'h66, 8'hA7, 8'h11};

  vec_t vecs [18];

  regfile_write_arbiter dut (
    .clock(clock), .reset(reset), .hold(hold),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_addr(reqAddr), .req_data(reqData),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .grant_id(grantId), .pending(pending), .contention(contention)
  );

  regfile_write_arbiter #(.CNT_W(2)) dutSmall (
    .clock(clock), .reset(reset), .hold(hold),
    .req_valid(reqValid), .req_ready(reqReadyS),
    .req_addr(reqAddr), .req_data(reqData),
    .regWrite(regWriteS), .writeRegister(writeRegisterS), .writeData(writeDataS),
    .grant_id(grantIdS), .pending(pendingS), .contention(contentionS)
  );

  always #5 clock = ~clock;

  // Register file consumer: commits whatever the arbiter presents at the end of the cycle.
  always @(posedge clock) begin
    if (regWrite) rf[writeRegister] <= writeData;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyReset(input int cycles);
    reset    = 1'b1;
    hold     = 1'b0;
    reqValid = 3'b000;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    hold     = v.hold;
    reqValid = v.valid;
    reqAddr  = v.addr;
    reqData  = v.data;
    #1;
    checkOutput($sformatf("v%0d ready", i), 32'(reqReady), 32'(v.expReady));
    @(posedge clock);
    #1;
    checkOutput($sformatf("v%0d regWrite", i), 32'(regWrite), 32'(v.expRegWrite));
    checkOutput($sformatf("v%0d writeRegister", i), 32'(writeRegister), 32'(v.expWriteReg));
    checkOutput($sformatf("v%0d writeData", i), 32'(writeData), 32'(v.expWriteData));
    checkOutput($sformatf("v%0d grant_id", i), 32'(grantId), 32'(v.expGrantId));
    checkOutput($sformatf("v%0d pending", i), 32'(pending), 32'(v.expPending));
    checkOutput($sformatf("v%0d contention", i), 32'(contention), 32'(v.expContention));
  endtask

  initial begin
    for (int r = 0; r < 8; r++) rf[r] = 8'h00;
    reqAddr = ADDRS;
    reqData = DATAS;

    //               hold  valid   addr    data   ready  rw    wr    wd     gid   pend   cnt
    vecs[0]  = '{1'b0, 3'b001, ADDRS,  DATAS, 3'b001, 1'b1, 3'd3, 8'h11, 2'd0, 8'h08, 8'd0};
    vecs[1]  = '{1'b0, 3'b010, ADDRS,  DATAS, 3'b010, 1'b1, 3'd5, 8'hA7, 2'd1, 8'h20, 8'd0};
    vecs[2]  = '{1'b0, 3'b000, ADDRS,  DATAS, 3'b000, 1'b0, 3'd5, 8'hA7, 2'd1, 8'h00, 8'd0};
    vecs[3]  = '{1'b0, 3'b100, ADDRS,  DATAS, 3'b100, 1'b1, 3'd6, 8'h66, 2'd2, 8'h40, 8'd0};
    vecs[4]  = '{1'b0, 3'b111, ADDRS,  DATAS, 3'b001, 1'b1, 3'd3, 8'h11, 2'd0, 8'h08, 8'd1};
    vecs[5]  = '{1'b0, 3'b111, ADDRS,  DATAS, 3'b010, 1'b1, 3'd5, 8'hA7, 2'd1, 8'h20, 8'd2};
    vecs[6]  = '{1'b0, 3'b111, ADDRS,  DATAS, 3'b100, 1'b1, 3'd6, 8'h66, 2'd2, 8'h40, 8'd3};
    vecs[7]  = '{1'b0, 3'b111, ADDRS,  DATAS, 3'b001, 1'b1, 3'd3, 8'h11, 2'd0, 8'h08, 8'd4};
    vecs[8]  = '{1'b0, 3'b111, ADDRS,  DATAS, 3'b010, 1'b1, 3'd5, 8'hA7, 2'd1, 8'h20, 8'd5};
    vecs[9]  = '{1'b0, 3'b111, ADDRS,  DATAS, 3'b100, 1'b1, 3'd6, 8'h66, 2'd2, 8'h40, 8'd6};
    vecs[10] = '{1'b0, 3'b100, ADDRS0, DATAS, 3'b100, 1'b0, 3'd6, 8'h66, 2'd2, 8'h00, 8'd6};
    vecs[11] = '{1'b1, 3'b011, ADDRS,  DATAS, 3'b000, 1'b0, 3'd6, 8'h66, 2'd2, 8'h00, 8'd7};
    vecs[12] = '{1'b1, 3'b011, ADDRS,  DATAS, 3'b000, 1'b0, 3'd6, 8'h66, 2'd2, 8'h00, 8'd8};
    vecs[13] = '{1'b1, 3'b011, ADDRS,  DATAS, 3'b000, 1'b0, 3'd6, 8'h66, 2'd2, 8'h00, 8'd9};
    vecs[14] = '{1'b0, 3'b011, ADDRS,  DATAS, 3'b001, 1'b1, 3'd3, 8'h11, 2'd0, 8'h08, 8'd10};
    vecs[15] = '{1'b0, 3'b011, ADDRS,  DATAS, 3'b010, 1'b1, 3'd5, 8'hA7, 2'd1, 8'h20, 8'd11};
    vecs[16] = '{1'b0, 3'b011, ADDRS,  DATAS, 3'b001, 1'b1, 3'd3, 8'h11, 2'd0, 8'h08, 8'd12};
    vecs[17] = '{1'b0, 3'b000, ADDRS,  DATAS, 3'b000, 1'b0, 3'd3, 8'h11, 2'd0, 8'h00, 8'd12};

    // Reset held with every requester asking: nothing may be accepted.
    reset    = 1'b1;
    hold     = 1'b0;
    reqValid = 3'b111;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset ready", 32'(reqReady), 32'h0);
    checkOutput("reset regWrite", 32'(regWrite), 32'h0);
    checkOutput("reset pending", 32'(pending), 32'h0);
    checkOutput("reset contention", 32'(contention), 32'h0);
    checkOutput("reset grant_id", 32'(grantId), 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("post-reset ready", 32'(reqReady), 32'b001);
    @(posedge clock);
    #1;
    checkOutput("post-reset regWrite", 32'(regWrite), 32'h1);
    checkOutput("post-reset writeRegister", 32'(writeRegister), 32'd3);
    checkOutput("post-reset contention", 32'(contention), 32'd1);

    applyReset(2);
    for (int i = 0; i < 18; i++) applyStimulus(vecs[i], i);

    checkOutput("rf[3]", 32'(rf[3]), 32'h11);
    checkOutput("rf[5]", 32'(rf[5]), 32'hA7);
    checkOutput("rf[6]", 32'(rf[6]), 32'h66);
    checkOutput("rf[0]", 32'(rf[0]), 32'h00);
    checkOutput("small contention saturated", 32'(contentionS), 32'd3);

    // Saturation: the 2-bit counter must stop at 3 while the 8-bit one keeps counting.
    applyReset(1);
    hold     = 1'b1;
    reqValid = 3'b111;
    reqAddr  = ADDRS;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("sat small after 2", 32'(contentionS), 32'd2);
    checkOutput("sat hold ready", 32'(reqReady), 32'h0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("sat main after 5", 32'(contention), 32'd5);
    checkOutput("sat small after 5", 32'(contentionS), 32'd3);

    // A write caught in the stage by reset must never reach the file.
    hold     = 1'b0;
    reqValid = 3'b010;
    reqData  = {8'h66, 8'h5A, 8'h11};
    #1;
    checkOutput("drop ready", 32'(reqReady), 32'b010);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    reqValid = 3'b000;
    #1;
    checkOutput("drop regWrite", 32'(regWrite), 32'h0);
    checkOutput("drop pending", 32'(pending), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("drop rf[5]", 32'(rf[5]), 32'hA7);
    checkOutput("drop regWrite after", 32'(regWrite), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
